// File: rtl/warmboot_sequencer_if.sv
// rtl/warmboot_sequencer_if.sv - boot-request handshake between requester and warm-boot sequencer
interface warmboot_sequencer_if;
  logic       REQ_VALID;
  logic [1:0] REQ_IMAGE;
  logic       REQ_READY;

  // Requester side: command decoder or button front-end
  modport master (
    output REQ_VALID,
    output REQ_IMAGE,
    input  REQ_READY
  );

  // Sequencer side: consumes requests
  modport slave (
    input  REQ_VALID,
    input  REQ_IMAGE,
    output REQ_READY
  );
endinterface

// File: rtl/warmboot_sequencer.sv
// rtl/warmboot_sequencer.sv - LED countdown then timed S1/S0 setup and BOOT drive for SB_WARMBOOT
module warmboot_sequencer #(
  parameter int HOLDOFF_LOG2 = 22,
  parameter int BLINKS       = 4,
  parameter int SETUP_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  warmboot_sequencer_if.slave  req,
  input  logic                 CANCEL,
  output logic                 BUSY,
  output logic                 WB_BOOT,
  output logic                 WB_S1,
  output logic                 WB_S0,
  output logic                 LED_R,
  output logic                 LED_G,
  output logic                 LED_B
);

  localparam int BW = $clog2(BLINKS + 1);
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int PW = HOLDOFF_LOG2;

  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINKS);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [SW-1:0] SETUP_ONE  = SW'(1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_SETUP     = 2'd2,
    S_BOOT      = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [1:0]     img_q;
  logic [PW-1:0]  prescaler_q;
  logic [BW-1:0]  blink_cnt_q;
  logic [SW-1:0]  setup_cnt_q;
  logic           blink_phase_q;

  // Control strobes decoded alongside the next state
  logic           accept;
  logic           tick_take;
  logic           enter_setup;
  logic           tick;
  logic           lit;
  logic           sel_r;
  logic           sel_g;
  logic           sel_b;

  // A tick is the last clock of each prescaler period
  assign tick = &prescaler_q;

  // State register; BOOT is terminal and only reset leaves it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and registered-state output decode
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    tick_take   = 1'b0;
    enter_setup = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req.REQ_VALID) begin
          accept  = 1'b1;
          state_d = S_COUNTDOWN;
        end
      end
      S_COUNTDOWN: begin
        // Cancel takes priority over a tick landing on the same clock
        if (CANCEL) begin
          state_d = S_IDLE;
        end else if (tick) begin
          tick_take = 1'b1;
          if (blink_cnt_q == BLINK_ONE) begin
            enter_setup = 1'b1;
            state_d     = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d = S_BOOT;
        end
      end
      S_BOOT: begin
        state_d = S_BOOT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Image latch: held from acceptance until the next acceptance
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      img_q <= 2'd0;
    end else if (accept) begin
      img_q <= req.REQ_IMAGE;
    end
  end

  // Free-running prescaler during the countdown, restarted on acceptance
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prescaler_q <= '0;
    end else if (accept) begin
      prescaler_q <= '0;
    end else if (state_q == S_COUNTDOWN) begin
      prescaler_q <= prescaler_q + PRE_ONE;
    end
  end

  // Blink counter and phase: one decrement and one toggle per taken tick
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (accept) begin
      blink_cnt_q   <= BLINK_LOAD;
      blink_phase_q <= 1'b0;
    end else if (tick_take) begin
      blink_cnt_q   <= blink_cnt_q - BLINK_ONE;
      blink_phase_q <= ~blink_phase_q;
    end
  end

  // Setup counter: cleared on entry, counts while waiting for BOOT, never wraps
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      setup_cnt_q <= '0;
    end else if (enter_setup) begin
      setup_cnt_q <= '0;
    end else if (state_q == S_SETUP && state_d == S_SETUP) begin
      setup_cnt_q <= setup_cnt_q + SETUP_ONE;
    end
  end

  // Output decode from state and registers only; no input reaches an output directly
  always_comb begin
    req.REQ_READY = (state_q == S_IDLE);
    BUSY          = (state_q != S_IDLE);
    WB_BOOT       = (state_q == S_BOOT);
    WB_S1         = (state_q != S_IDLE) & img_q[1];
    WB_S0         = (state_q != S_IDLE) & img_q[0];
    sel_r         = (img_q == 2'd0) | (img_q == 2'd3);
    sel_g         = (img_q == 2'd1) | (img_q == 2'd3);
    sel_b         = (img_q == 2'd2) | (img_q == 2'd3);
    lit           = ((state_q == S_COUNTDOWN) & ~blink_phase_q) |
                    (state_q == S_SETUP) | (state_q == S_BOOT);
    LED_R         = ~(lit & sel_r);
    LED_G         = ~(lit & sel_g);
    LED_B         = ~(lit & sel_b);
  end

endmodule
